// File: rtl/clk_div_monitor.sv
// clk_div_monitor: divided-clock period/duty meter with lock and timeout flags; define CLK_DIV_MON_SYNC_EN for a 2-flop input synchronizer
module clk_div_monitor #(
    parameter int DIV_EXP    = 5,
    parameter int LOCK_CNT   = 4,
    parameter int MAX_PERIOD = 255,
    localparam int W         = $clog2(MAX_PERIOD + 1)
) (
    input  logic         i_clk_in,
    input  logic         i_rst,
    input  logic         i_sig,
    output logic         o_valid,
    output logic [W-1:0] o_period,
    output logic [W-1:0] o_high,
    output logic         o_lock,
    output logic         o_timeout
);
    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam logic [W-1:0]  MAX_W  = W'(MAX_PERIOD);
    localparam logic [W-1:0]  DIV_W  = W'(DIV_EXP);
    localparam logic [W-1:0]  HLO_W  = W'(DIV_EXP / 2);
    localparam logic [W-1:0]  HHI_W  = W'((DIV_EXP + 1) / 2);
    localparam logic [CW-1:0] LOCK_C = CW'(LOCK_CNT);

    typedef enum logic [1:0] {S_WAIT, S_RUN, S_STALL} state_t;

    state_t        state_q, state_d;
    logic          s_q, sd_q, rise;
    logic [W-1:0]  per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
    logic [W-1:0]  period_q, period_d, high_q, high_d;
    logic [CW-1:0] match_q, match_d;
    logic          valid_q, valid_d, lock_q, lock_d, timeout_q, timeout_d;
    logic          per_full, is_match;

`ifdef CLK_DIV_MON_SYNC_EN
    logic meta_q;
    // two-flop synchronizer for asynchronous or negedge-generated sources
    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            meta_q <= 1'b0;
            s_q    <= 1'b0;
        end else begin
            meta_q <= i_sig;
            s_q    <= meta_q;
        end
    end
`else
    // single capture flop for a posedge-synchronous source
    always_ff @(posedge i_clk_in) begin
        s_q <= i_rst ? 1'b0 : i_sig;
    end
`endif

    assign rise     = s_q & ~sd_q;
    assign per_full = per_cnt_q == MAX_W;
    assign is_match = per_cnt_q == DIV_W && (hi_cnt_q == HLO_W || hi_cnt_q == HHI_W);

    // measurement counters, lock tracking and state transitions
    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        period_d = period_q;
        high_d   = high_q;
        match_d  = match_q;
        per_cnt_d = rise ? W'(1) : per_full ? per_cnt_q : per_cnt_q + W'(1);
        hi_cnt_d  = rise ? W'(1) : (s_q && hi_cnt_q != MAX_W) ? hi_cnt_q + W'(1) : hi_cnt_q;
        if (rise) begin
            state_d = S_RUN;
            if (state_q == S_RUN) begin
                valid_d  = 1'b1;
                period_d = per_cnt_q;
                high_d   = hi_cnt_q;
                match_d  = !is_match ? '0 : (match_q == LOCK_C) ? match_q : match_q + CW'(1);
            end
        end else if (per_full) begin
            state_d = S_STALL;
            match_d = '0;
        end
        lock_d    = match_d == LOCK_C;
        timeout_d = state_d == S_STALL;
    end

    // state and output registers
    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            state_q   <= S_WAIT;
            sd_q      <= 1'b0;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            match_q   <= '0;
            valid_q   <= 1'b0;
            lock_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sd_q      <= s_q;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            match_q   <= match_d;
            valid_q   <= valid_d;
            lock_q    <= lock_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_period  = period_q;
    assign o_high    = high_q;
    assign o_lock    = lock_q;
    assign o_timeout = timeout_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed table-driven checks of the monitor; expectations assume the single capture flop build
module tb_clk_div_monitor;
    logic       clk = 1'b0, rst = 1'b1, sig = 1'b0, sig2 = 1'b0;
    logic       v5, l5, t5, v2, l2, t2;
    logic [7:0] p5, h5, p2, h2;
    int         n_chk = 0, n_fail = 0;

    typedef struct {
        int   hi;
        int   lo;
        logic v;
        int   per;
        int   high;
        logic lock;
        logic to;
    } vec_t;

    vec_t tbl[18];

    clk_div_monitor dut5 (
        .i_clk_in(clk), .i_rst(rst), .i_sig(sig),
        .o_valid(v5), .o_period(p5), .o_high(h5), .o_lock(l5), .o_timeout(t5)
    );

    clk_div_monitor #(.DIV_EXP(2), .LOCK_CNT(1), .MAX_PERIOD(255)) dut2 (
        .i_clk_in(clk), .i_rst(rst), .i_sig(sig2),
        .o_valid(v2), .o_period(p2), .o_high(h2), .o_lock(l2), .o_timeout(t2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic s2);
        sig  = s;
        sig2 = s2;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, v5, 0);
        chk({name, "_period"}, p5, 0);
        chk({name, "_high"}, h5, 0);
        chk({name, "_lock"}, l5, 0);
        chk({name, "_timeout"}, t5, 0);
    endtask

    task automatic run_rec(input vec_t r);
        for (int i = 0; i < r.hi + r.lo; i++) begin
            step(i < r.hi, 1'b0);
            if (i == 1) begin
                chk("rec_valid", v5, r.v);
                chk("rec_period", p5, r.per);
                chk("rec_high", h5, r.high);
                chk("rec_lock", l5, r.lock);
                chk("rec_timeout", t5, r.to);
            end else begin
                chk("idle_valid", v5, 0);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{2, 3, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[1]  = '{2, 3, 1'b1, 5, 2, 1'b0, 1'b0};
        tbl[2]  = '{2, 3, 1'b1, 5, 2, 1'b0, 1'b0};
        tbl[3]  = '{2, 3, 1'b1, 5, 2, 1'b0, 1'b0};
        tbl[4]  = '{2, 3, 1'b1, 5, 2, 1'b1, 1'b0};
        tbl[5]  = '{3, 3, 1'b1, 5, 2, 1'b1, 1'b0};
        tbl[6]  = '{3, 3, 1'b1, 6, 3, 1'b0, 1'b0};
        tbl[7]  = '{3, 3, 1'b1, 6, 3, 1'b0, 1'b0};
        tbl[8]  = '{2, 3, 1'b1, 6, 3, 1'b0, 1'b0};
        tbl[9]  = '{2, 3, 1'b1, 5, 2, 1'b0, 1'b0};
        tbl[10] = '{2, 3, 1'b1, 5, 2, 1'b0, 1'b0};
        tbl[11] = '{2, 3, 1'b1, 5, 2, 1'b0, 1'b0};
        tbl[12] = '{2, 3, 1'b1, 5, 2, 1'b1, 1'b0};
        tbl[13] = '{2, 3, 1'b0, 5, 2, 1'b0, 1'b0};
        tbl[14] = '{2, 3, 1'b1, 5, 2, 1'b0, 1'b0};
        tbl[15] = '{2, 3, 1'b1, 5, 2, 1'b0, 1'b0};
        tbl[16] = '{2, 3, 1'b1, 5, 2, 1'b0, 1'b0};
        tbl[17] = '{2, 3, 1'b1, 5, 2, 1'b1, 1'b0};

        rst = 1'b1;
        step(1'b1, 1'b0);
        chk_zero("rst0");
        step(1'b0, 1'b0);
        chk_zero("rst1");
        step(1'b1, 1'b0);
        chk_zero("rst2");
        rst = 1'b0;

        for (int i = 0; i <= 12; i++) run_rec(tbl[i]);

        repeat (251) step(1'b0, 1'b0);
        chk("pre_timeout", t5, 0);
        chk("pre_timeout_lock", l5, 1);
        step(1'b0, 1'b0);
        chk("timeout", t5, 1);
        chk("timeout_lock", l5, 0);
        chk("timeout_valid", v5, 0);
        repeat (44) step(1'b0, 1'b0);
        chk("timeout_hold", t5, 1);
        chk("timeout_hold_lock", l5, 0);

        for (int i = 13; i <= 17; i++) run_rec(tbl[i]);

        rst = 1'b1;
        step(1'b0, 1'b0);
        chk_zero("midrst");
        rst = 1'b0;
        for (int i = 0; i <= 4; i++) run_rec(tbl[i]);

        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("p2_first_valid", v2, 0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("p2_valid", v2, 1);
        chk("p2_period", p2, 2);
        chk("p2_high", h2, 1);
        chk("p2_lock", l2, 1);
        chk("p2_timeout", t2, 0);
        step(1'b0, 1'b1);
        chk("p2_gap_valid", v2, 0);
        step(1'b0, 1'b0);
        chk("p2_valid2", v2, 1);
        chk("p2_lock2", l2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
